// File: rtl/cby_param.sv
// Parametrised Y-direction connection block: track pass-through, scan-chain configured IPIN muxes,
// configuration-complete gating. Optional even-parity check on the loaded chain via `CBY_CFG_PARITY_EN.
module cby_param #(
    parameter int CHAN_W   = 10,
    parameter int NUM_IPIN = 11,
    parameter int MUX_SIZE = 4
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                ccff_en,
    input  logic                ccff_head,
    output logic                ccff_tail,
    input  logic [CHAN_W-1:0]   chany_bottom_in,
    input  logic [CHAN_W-1:0]   chany_top_in,
    output logic [CHAN_W-1:0]   chany_bottom_out,
    output logic [CHAN_W-1:0]   chany_top_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    output logic                cfg_done,
    output logic                cfg_err
);

    localparam int SEL_W = ($clog2(MUX_SIZE) < 1) ? 1 : $clog2(MUX_SIZE);
    localparam int L     = NUM_IPIN * SEL_W;
`ifdef CBY_CFG_PARITY_EN
    localparam int C     = L + 1;
`else
    localparam int C     = L;
`endif
    localparam int CNT_W = $clog2(C + 1);

    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(C);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C - 1);
    localparam logic [SEL_W:0]   MUX_N  = (SEL_W + 1)'(MUX_SIZE);

    logic [C-1:0]        cfg_q, cfg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cfg_done_q, cfg_done_d;
    logic [NUM_IPIN-1:0] mux_o;

    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;

    // NOTE: every always_comb output gets its hold value first so no path can infer a latch.
    always_comb begin
        cfg_d      = cfg_q;
        cnt_d      = cnt_q;
        cfg_done_d = cfg_done_q;
        if (ccff_en) begin
            // Truncating cast drops the old MSB, which has already left through ccff_tail.
            cfg_d = C'({cfg_q, ccff_head});
            if (cnt_q != C_FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q == C_LAST) begin
                cfg_done_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            cfg_q      <= '0;
            cnt_q      <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            cfg_done_q <= cfg_done_d;
        end
    end

`ifdef CBY_CFG_PARITY_EN
    logic cfg_err_q, cfg_err_d;

    // Once the chain is full, re-evaluate parity every edge so a reload is re-checked.
    always_comb begin
        cfg_err_d = cfg_err_q;
        if (cnt_q == C_FULL) begin
            cfg_err_d = ^cfg_q;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;
`else
    assign cfg_err = 1'b0;
`endif

    // Mux input k of ipin i taps track (i*MUX_SIZE/2 + k/2) mod CHAN_W; even k bottom, odd k top.
    for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_ipin
        logic [MUX_SIZE-1:0] taps;
        logic [SEL_W-1:0]    sel;

        for (genvar gk = 0; gk < MUX_SIZE; gk++) begin : g_tap
            localparam int T = (gi * (MUX_SIZE / 2) + gk / 2) % CHAN_W;
            if (gk % 2 == 0) begin : g_bot
                assign taps[gk] = chany_bottom_in[T];
            end else begin : g_top
                assign taps[gk] = chany_top_in[T];
            end
        end

        assign sel       = cfg_q[gi*SEL_W +: SEL_W];
        assign mux_o[gi] = ({1'b0, sel} < MUX_N) ? taps[sel] : 1'b0;
    end

    assign ccff_tail = cfg_q[C-1];
    assign cfg_done  = cfg_done_q;
    assign ipin_out  = mux_o & {NUM_IPIN{cfg_done_q & ~ccff_en & ~cfg_err}};

endmodule

// File: tb/tb_cby_param.sv
// Directed bench for cby_param: a 4-IPIN instance for the main scenarios and a 6-IPIN instance
// for the track wrap-around. Parity scenarios run when CBY_CFG_PARITY_EN is defined.
module tb_cby_param;

    logic       prog_clk = 1'b0;
    logic       p_reset  = 1'b0;
    logic       ccff_en  = 1'b0;
    logic       ccff_head = 1'b0;
    logic       en6 = 1'b0;
    logic       head6 = 1'b0;
    logic [9:0] bot_in = '0;
    logic [9:0] top_in = '0;

    logic [9:0] bot_out4, top_out4, bot_out6, top_out6;
    logic [3:0] ipin4;
    logic [5:0] ipin6;
    logic       tail4, done4, err4, tail6, done6, err6;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 prog_clk = ~prog_clk;

    cby_param #(.CHAN_W(10), .NUM_IPIN(4), .MUX_SIZE(4)) u_dut4 (
        .prog_clk        (prog_clk),
        .pReset          (p_reset),
        .ccff_en         (ccff_en),
        .ccff_head       (ccff_head),
        .ccff_tail       (tail4),
        .chany_bottom_in (bot_in),
        .chany_top_in    (top_in),
        .chany_bottom_out(bot_out4),
        .chany_top_out   (top_out4),
        .ipin_out        (ipin4),
        .cfg_done        (done4),
        .cfg_err         (err4)
    );

    cby_param #(.CHAN_W(10), .NUM_IPIN(6), .MUX_SIZE(4)) u_dut6 (
        .prog_clk        (prog_clk),
        .pReset          (p_reset),
        .ccff_en         (en6),
        .ccff_head       (head6),
        .ccff_tail       (tail6),
        .chany_bottom_in (bot_in),
        .chany_top_in    (top_in),
        .chany_bottom_out(bot_out6),
        .chany_top_out   (top_out6),
        .ipin_out        (ipin6),
        .cfg_done        (done6),
        .cfg_err         (err6)
    );

    task automatic shift4(input logic b);
        @(negedge prog_clk);
        ccff_head = b;
        ccff_en   = 1'b1;
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift6(input logic b);
        @(negedge prog_clk);
        head6 = b;
        en6   = 1'b1;
        @(posedge prog_clk);
        #1;
    endtask

    task automatic stop4();
        @(negedge prog_clk);
        ccff_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        p_reset = 1'b0;
        for (int v = 0; v < 3; v++) begin
            bot_in = 10'($urandom);
            top_in = 10'($urandom);
            #3;
            total_cnt++;
            if (top_out4 !== bot_in) $display("FAIL rst_top_out: got %h expected %h", top_out4, bot_in);
            else pass_cnt++;
            total_cnt++;
            if (bot_out4 !== top_in) $display("FAIL rst_bot_out: got %h expected %h", bot_out4, top_in);
            else pass_cnt++;
            total_cnt++;
            if (ipin4 !== 4'h0) $display("FAIL rst_ipin: got %h expected 0", ipin4);
            else pass_cnt++;
            total_cnt++;
            if (done4 !== 1'b0) $display("FAIL rst_done: got %b expected 0", done4);
            else pass_cnt++;
            total_cnt++;
            if (tail4 !== 1'b0) $display("FAIL rst_tail: got %b expected 0", tail4);
            else pass_cnt++;
            total_cnt++;
            if (err4 !== 1'b0) $display("FAIL rst_err: got %b expected 0", err4);
            else pass_cnt++;
        end
        // Shifting ones while held in reset must not load anything.
        for (int j = 0; j < 10; j++) shift4(1'b1);
        total_cnt++;
        if (tail4 !== 1'b0 || done4 !== 1'b0)
            $display("FAIL rst_shift_held: got tail=%b done=%b expected 0 0", tail4, done4);
        else pass_cnt++;
        @(negedge prog_clk);
        ccff_en = 1'b0;
        p_reset = 1'b1;
    endtask

    task automatic load8_check_done(input logic [7:0] v, input string tag);
        for (int i = 7; i >= 0; i--) begin
            shift4(v[i]);
            total_cnt++;
            if (done4 !== (i == 0)) $display("FAIL %s_done_edge%0d: got %b expected %b", tag, 8 - i, done4, (i == 0));
            else pass_cnt++;
        end
        total_cnt++;
        if (ipin4 !== 4'h0) $display("FAIL %s_ipin_en_high: got %h expected 0", tag, ipin4);
        else pass_cnt++;
        stop4();
    endtask

    task automatic test_program();
        logic [9:0] vb [5] = '{10'h001, 10'h3FE, 10'h000, 10'h3FF, 10'h3DE};
        logic [9:0] vt [5] = '{10'h000, 10'h004, 10'h080, 10'h3FF, 10'h37B};
        logic [3:0] ve [5] = '{4'b0001, 4'b0110, 4'b1000, 4'b1111, 4'b0000};
        bot_in = '1;
        top_in = '1;
        load8_check_done(8'hE4, "prog");
        total_cnt++;
        if (tail4 !== 1'b1) $display("FAIL prog_tail: got %b expected 1", tail4);
        else pass_cnt++;
        for (int v = 0; v < 5; v++) begin
            bot_in = vb[v];
            top_in = vt[v];
            #1;
            total_cnt++;
            if (ipin4 !== ve[v]) $display("FAIL prog_ipin_vec%0d: got %b expected %b", v, ipin4, ve[v]);
            else pass_cnt++;
        end
    endtask

    task automatic test_chain();
        logic [15:0] data = 16'hA53C;
        logic [7:0]  tail_byte = '0;
        logic [9:0]  vb [3] = '{10'h041, 10'h000, 10'h3BE};
        logic [9:0]  vt [3] = '{10'h000, 10'h028, 10'h3D7};
        logic [3:0]  ve [3] = '{4'b1001, 4'b0110, 4'b0000};
        bot_in = '1;
        top_in = '1;
        for (int j = 0; j < 16; j++) begin
            @(negedge prog_clk);
            if (j >= 8) tail_byte = {tail_byte[6:0], tail4};
            ccff_head = data[15-j];
            ccff_en   = 1'b1;
            @(posedge prog_clk);
            #1;
            total_cnt++;
            if (ipin4 !== 4'h0) $display("FAIL chain_ipin_gated_edge%0d: got %h expected 0", j + 1, ipin4);
            else pass_cnt++;
        end
        total_cnt++;
        if (tail_byte !== 8'hA5) $display("FAIL chain_tail_byte: got %h expected a5", tail_byte);
        else pass_cnt++;
        total_cnt++;
        if (done4 !== 1'b1) $display("FAIL chain_done_sticky: got %b expected 1", done4);
        else pass_cnt++;
        stop4();
        for (int v = 0; v < 3; v++) begin
            bot_in = vb[v];
            top_in = vt[v];
            #1;
            total_cnt++;
            if (ipin4 !== ve[v]) $display("FAIL chain_ipin_vec%0d: got %b expected %b", v, ipin4, ve[v]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        bot_in = '1;
        top_in = '1;
        for (int j = 0; j < 5; j++) shift4(1'b1);
        #2;
        p_reset = 1'b0;
        #1;
        total_cnt++;
        if (done4 !== 1'b0 || tail4 !== 1'b0 || ipin4 !== 4'h0)
            $display("FAIL mid_rst_state: got done=%b tail=%b ipin=%h expected 0 0 0", done4, tail4, ipin4);
        else pass_cnt++;
        @(negedge prog_clk);
        ccff_en = 1'b0;
        p_reset = 1'b1;
        load8_check_done(8'h1B, "reload");
        bot_in = 10'h048;
        top_in = 10'h000;
        #1;
        total_cnt++;
        if (ipin4 !== 4'b1010) $display("FAIL reload_ipin_vec0: got %b expected 1010", ipin4);
        else pass_cnt++;
        bot_in = 10'h000;
        top_in = 10'h012;
        #1;
        total_cnt++;
        if (ipin4 !== 4'b0101) $display("FAIL reload_ipin_vec1: got %b expected 0101", ipin4);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [11:0] data = 12'hC00;
        logic [9:0]  vb [3] = '{10'h000, 10'h155, 10'h000};
        logic [9:0]  vt [3] = '{10'h002, 10'h3FD, 10'h001};
        logic [5:0]  ve [3] = '{6'b100000, 6'b011111, 6'b000000};
        for (int i = 11; i >= 0; i--) shift6(data[i]);
        @(negedge prog_clk);
        en6 = 1'b0;
        #1;
        total_cnt++;
        if (done6 !== 1'b1) $display("FAIL wrap_done: got %b expected 1", done6);
        else pass_cnt++;
        for (int v = 0; v < 3; v++) begin
            bot_in = vb[v];
            top_in = vt[v];
            #1;
            total_cnt++;
            if (ipin6 !== ve[v]) $display("FAIL wrap_ipin_vec%0d: got %b expected %b", v, ipin6, ve[v]);
            else pass_cnt++;
        end
    endtask

    task automatic test_parity();
        logic [8:0] bad  = 9'h1E4;
        logic [8:0] good = 9'h0E4;
        bot_in = '1;
        top_in = '1;
        @(negedge prog_clk);
        p_reset = 1'b1;
        for (int i = 8; i >= 0; i--) shift4(bad[i]);
        stop4();
        @(posedge prog_clk);
        #1;
        total_cnt++;
        if (err4 !== 1'b1) $display("FAIL par_err_bad: got %b expected 1", err4);
        else pass_cnt++;
        total_cnt++;
        if (ipin4 !== 4'h0) $display("FAIL par_ipin_bad: got %h expected 0", ipin4);
        else pass_cnt++;
        for (int i = 8; i >= 0; i--) shift4(good[i]);
        stop4();
        @(posedge prog_clk);
        #1;
        total_cnt++;
        if (err4 !== 1'b0) $display("FAIL par_err_good: got %b expected 0", err4);
        else pass_cnt++;
        total_cnt++;
        if (ipin4 !== 4'hF) $display("FAIL par_ipin_good: got %h expected f", ipin4);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
`ifdef CBY_CFG_PARITY_EN
        test_parity();
`else
        test_program();
        test_chain();
        test_reset_mid();
        test_wrap();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
